// File: rtl/register_file_pkg.sv
`default_nettype none
// ============================================================================
// Module      : register_file_pkg
// Description : Shared constants for the UART-side register file. These are
//               the reserved entry addresses, their reset values, and the
//               bit-field positions inside UART_config.
// Revision    : 1.0 - initial release
// ============================================================================
package register_file_pkg;

    // Reserved low addresses that are mirrored onto dedicated outputs
    localparam int OPERAND_A_ADDRESS      = 0;
    localparam int OPERAND_B_ADDRESS      = 1;
    localparam int UART_CONFIG_ADDRESS    = 2;
    localparam int DIVISION_RATIO_ADDRESS = 3;

    // Reset contents of the configuration entries
    // UART_config reset: prescale 32, even parity, parity enabled
    localparam logic [7:0] UART_CONFIG_RESET    = 8'b1000_0001;
    localparam logic [7:0] DIVISION_RATIO_RESET = 8'h20;

    // UART_config bit fields
    localparam int UART_PARITY_ENABLE_BIT = 0;
    localparam int UART_PARITY_TYPE_BIT   = 1;   // 0 = even, 1 = odd
    localparam int UART_PRESCALE_LSB      = 2;
    localparam int UART_PRESCALE_MSB      = 7;

endpackage : register_file_pkg
`default_nettype wire

// File: rtl/register_file_if.sv
`default_nettype none
// ============================================================================
// Module      : register_file_if
// Description : Bus between the UART receive controller (master) and the
//               register file (slave). It carries the access strobes, the
//               registered read return, and the always-valid configuration
//               outputs. access_collision exists only when
//               REGISTER_FILE_COLLISION_FLAG_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface register_file_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    import register_file_pkg::*;

    logic [ADDR_WIDTH-1:0] address;
    logic                  write_enable;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  read_enable;
    logic [DATA_WIDTH-1:0] read_data;
    logic                  read_data_valid;
    logic [DATA_WIDTH-1:0] operand_A;
    logic [DATA_WIDTH-1:0] operand_B;
    logic [DATA_WIDTH-1:0] UART_config;
    logic [DATA_WIDTH-1:0] division_ratio;
`ifdef REGISTER_FILE_COLLISION_FLAG_EN
    logic                  access_collision;
`endif

    modport master (
        output address, write_enable, write_data, read_enable,
        input  read_data, read_data_valid,
        input  operand_A, operand_B, UART_config, division_ratio
`ifdef REGISTER_FILE_COLLISION_FLAG_EN
        , input access_collision
`endif
    );

    modport slave (
        input  address, write_enable, write_data, read_enable,
        output read_data, read_data_valid,
        output operand_A, operand_B, UART_config, division_ratio
`ifdef REGISTER_FILE_COLLISION_FLAG_EN
        , output access_collision
`endif
    );

endinterface : register_file_if
`default_nettype wire

// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
// Module      : register_file
// Description : Register file downstream of the UART receive controller.
//               Writes land on the clock edge. Reads return registered data
//               with a one-cycle valid pulse. Entries 0..3 are mirrored
//               continuously as operand_A, operand_B, UART_config and
//               division_ratio. When a write and a read are strobed in the
//               same cycle, the write wins and the read is dropped.
//               Optional: REGISTER_FILE_COLLISION_FLAG_EN adds
//               access_collision, which pulses after a same-cycle write/read
//               or after a strobe to an out-of-range address.
// Revision    : 1.0 - initial release
// ============================================================================
module register_file
    import register_file_pkg::*;
#(
    parameter int DATA_WIDTH          = 8,
    parameter int REGISTER_FILE_DEPTH = 16
) (
    input  wire logic         clk,
    input  wire logic         reset,
    register_file_if.slave    bus
);

    localparam int ADDR_WIDTH = $clog2(REGISTER_FILE_DEPTH);

    localparam logic [DATA_WIDTH-1:0] c_UART_CONFIG_RESET    = DATA_WIDTH'(UART_CONFIG_RESET);
    localparam logic [DATA_WIDTH-1:0] c_DIVISION_RATIO_RESET = DATA_WIDTH'(DIVISION_RATIO_RESET);

    logic [DATA_WIDTH-1:0] r_mem [REGISTER_FILE_DEPTH];
    logic [DATA_WIDTH-1:0] r_read_data;
    logic                  r_read_data_valid;

    logic [ADDR_WIDTH-1:0] w_address;
    logic                  w_addr_in_range;
    logic                  w_do_write;
    logic                  w_do_read;

    assign w_address       = bus.address;
    // With a non-power-of-2 depth, upper codes select no entry at all
    assign w_addr_in_range = (int'(w_address) < REGISTER_FILE_DEPTH);
    assign w_do_write      = bus.write_enable && w_addr_in_range;
    // A read strobed together with a write is dropped, not deferred
    assign w_do_read       = bus.read_enable && !bus.write_enable && w_addr_in_range;

    // Storage: reset loads the configuration defaults, otherwise accept the write
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < REGISTER_FILE_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_mem[UART_CONFIG_ADDRESS]    <= c_UART_CONFIG_RESET;
            r_mem[DIVISION_RATIO_ADDRESS] <= c_DIVISION_RATIO_RESET;
        end else if (w_do_write) begin
            r_mem[w_address] <= bus.write_data;
        end
    end

    // Read return: data holds between reads, valid pulses once per accepted read
    always_ff @(posedge clk) begin
        if (reset) begin
            r_read_data       <= '0;
            r_read_data_valid <= 1'b0;
        end else begin
            r_read_data_valid <= w_do_read;
            if (w_do_read) begin
                r_read_data <= r_mem[w_address];
            end
        end
    end

    assign bus.read_data       = r_read_data;
    assign bus.read_data_valid = r_read_data_valid;

    // Reserved entries are always visible to the ALU and UART/clock divider
    assign bus.operand_A      = r_mem[OPERAND_A_ADDRESS];
    assign bus.operand_B      = r_mem[OPERAND_B_ADDRESS];
    assign bus.UART_config    = r_mem[UART_CONFIG_ADDRESS];
    assign bus.division_ratio = r_mem[DIVISION_RATIO_ADDRESS];

`ifdef REGISTER_FILE_COLLISION_FLAG_EN
    logic r_access_collision;

    // Flag a conflicting or out-of-range strobe for one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_access_collision <= 1'b0;
        end else begin
            r_access_collision <= (bus.write_enable && bus.read_enable) ||
                                  ((bus.write_enable || bus.read_enable) && !w_addr_in_range);
        end
    end

    assign bus.access_collision = r_access_collision;
`endif

endmodule : register_file
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_file
// Description : Self-checking bench for register_file. It uses directed
//               vectors with hand-computed expectations, plus a
//               reset-during-read sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file;

    localparam int DATA_WIDTH = 8;
    localparam int DEPTH      = 16;
    localparam int AW         = $clog2(DEPTH);

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_fails  = 0;

    register_file_if #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(AW)) bus ();

    register_file #(
        .DATA_WIDTH          (DATA_WIDTH),
        .REGISTER_FILE_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          we;
        logic          re;
        logic [AW-1:0] addr;
        logic [7:0]    wd;
        logic          e_valid;
        logic [7:0]    e_rd;
        logic [7:0]    e_a;
        logic [7:0]    e_b;
        logic [7:0]    e_uart;
        logic [7:0]    e_div;
        logic          e_col;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input vec_t v);
        check({tag, " valid"},   {7'd0, bus.read_data_valid}, {7'd0, v.e_valid});
        check({tag, " rdata"},   bus.read_data,       v.e_rd);
        check({tag, " opA"},     bus.operand_A,       v.e_a);
        check({tag, " opB"},     bus.operand_B,       v.e_b);
        check({tag, " uart"},    bus.UART_config,     v.e_uart);
        check({tag, " divrat"},  bus.division_ratio,  v.e_div);
`ifdef REGISTER_FILE_COLLISION_FLAG_EN
        check({tag, " collide"}, {7'd0, bus.access_collision}, {7'd0, v.e_col});
`endif
    endtask

    initial begin
        vec_t v;
        //              we    re    addr   wd     val  rd     A      B      uart   div   col
        vecs[0]  = '{1'b1, 1'b0, 4'd13, 8'hCF, 1'b0, 8'h00, 8'h00, 8'h00, 8'h81, 8'h20, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 4'd13, 8'h00, 1'b1, 8'hCF, 8'h00, 8'h00, 8'h81, 8'h20, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 4'd0,  8'h00, 1'b0, 8'hCF, 8'h00, 8'h00, 8'h81, 8'h20, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 4'd0,  8'h09, 1'b0, 8'hCF, 8'h09, 8'h00, 8'h81, 8'h20, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 4'd1,  8'h0A, 1'b0, 8'hCF, 8'h09, 8'h0A, 8'h81, 8'h20, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 4'd8,  8'h00, 1'b1, 8'h00, 8'h09, 8'h0A, 8'h81, 8'h20, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 4'd5,  8'h3C, 1'b0, 8'h00, 8'h09, 8'h0A, 8'h81, 8'h20, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 4'd5,  8'h00, 1'b1, 8'h3C, 8'h09, 8'h0A, 8'h81, 8'h20, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 4'd2,  8'h00, 1'b1, 8'h81, 8'h09, 8'h0A, 8'h81, 8'h20, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 4'd3,  8'h00, 1'b1, 8'h20, 8'h09, 8'h0A, 8'h81, 8'h20, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 4'd4,  8'h00, 1'b1, 8'h00, 8'h09, 8'h0A, 8'h81, 8'h20, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 4'd4,  8'h00, 1'b0, 8'h00, 8'h09, 8'h0A, 8'h81, 8'h20, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 4'd2,  8'h42, 1'b0, 8'h00, 8'h09, 8'h0A, 8'h42, 8'h20, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 4'd2,  8'h00, 1'b1, 8'h42, 8'h09, 8'h0A, 8'h42, 8'h20, 1'b0};

        bus.address      = '0;
        bus.write_enable = 1'b0;
        bus.write_data   = '0;
        bus.read_enable  = 1'b0;

        // Hold reset for two edges, then release and check the reset image
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        v = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h81, 8'h20, 1'b0};
        check_outputs("reset", v);

        // Apply each vector before an edge, then check outputs after that edge
        for (int i = 0; i < NV; i++) begin
            bus.write_enable = vecs[i].we;
            bus.read_enable  = vecs[i].re;
            bus.address      = vecs[i].addr;
            bus.write_data   = vecs[i].wd;
            @(negedge clk);
            check_outputs($sformatf("vec%0d", i), vecs[i]);
        end

        // Write entry 2, then reset during a read. The read must be discarded
        // and the configuration must return to its default.
        bus.write_enable = 1'b1;
        bus.read_enable  = 1'b0;
        bus.address      = 4'd2;
        bus.write_data   = 8'h5A;
        @(negedge clk);
        check("pre-reset uart", bus.UART_config, 8'h5A);
        bus.write_enable = 1'b0;
        bus.read_enable  = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.read_enable  = 1'b0;
        v = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h81, 8'h20, 1'b0};
        check_outputs("rst-mid", v);
        @(negedge clk);
        check_outputs("rst-after", v);

        // Entries 5 and 13 were cleared by the reset
        bus.read_enable = 1'b1;
        bus.address     = 4'd13;
        @(negedge clk);
        check("post-rst rd13 valid", {7'd0, bus.read_data_valid}, 8'h01);
        check("post-rst rd13 data", bus.read_data, 8'h00);
        bus.address = 4'd5;
        @(negedge clk);
        check("post-rst rd5 data", bus.read_data, 8'h00);
        bus.read_enable = 1'b0;
        @(negedge clk);
        check("post-rst idle valid", {7'd0, bus.read_data_valid}, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_register_file
`default_nettype wire
